// File: rtl/synth_pkg.sv
// Shared types for the keyboard front end: key count, note index and
// scheduler state encoding, plus a lowest-set-bit helper for arbitration.
package synth_pkg;

   localparam int NUM_KEYS = 12;

   typedef logic [3:0] note_idx_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WAIT = 2'd2
   } sched_state_t;

   // Index of the lowest set bit; 0 when the vector is empty.
   function automatic note_idx_t lowest_idx(input logic [NUM_KEYS-1:0] v);
      note_idx_t r;
      r = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (v[i]) r = note_idx_t'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Single-key debouncer: the stable level flips only after the raw input has
// disagreed with it on DEBOUNCE_TICKS consecutive sample ticks.
module key_debouncer #(
   parameter int DEBOUNCE_TICKS = 240
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_tick,
   input  logic raw,
   output logic db
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         db  <= 1'b0;
         cnt <= '0;
      end else if (sample_tick) begin
         if (raw != db) begin
            if (cnt == 8'(DEBOUNCE_TICKS - 1)) begin
               db  <= ~db;
               cnt <= '0;
            end else begin
               cnt <= cnt + 8'd1;
            end
         end else begin
            // any sample agreeing with the stable level restarts the count
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/note_key_scheduler.sv
// Debounced last-note-priority key arbitration; note changes are deferred to
// a wave half-period boundary (or a tick timeout) so no half-cycle is cut short.
module note_key_scheduler
   import synth_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 240,
   parameter int EDGE_TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] keys,
   input  logic        sample_tick,
   input  logic        wave_edge,
   output logic [11:0] key_sel,
   output logic        note_on,
   output logic [3:0]  note_idx,
   output logic        pending,
   output logic [1:0]  dbg_state
);

   logic [NUM_KEYS-1:0] db, db_prev, press;
   note_idx_t           latest, latest_n;
   logic                lvalid, lvalid_n;

   sched_state_t        state, state_n;
   note_idx_t           idx_n;
   logic                on_n;
   logic [11:0]         sel_n;
   logic [7:0]          tcnt, tcnt_n;
   logic                timeout_hit;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_db
      key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
         .clk         (clk),
         .rst         (rst),
         .sample_tick (sample_tick),
         .raw         (keys[i]),
         .db          (db[i])
      );
   end

   assign press = db & ~db_prev;

   // Press first, then fall back to the lowest held key if latest is gone.
   always_comb begin
      latest_n = latest;
      lvalid_n = lvalid;
      if (|press) begin
         latest_n = lowest_idx(press);
         lvalid_n = 1'b1;
      end
      if (!(lvalid_n && db[latest_n])) begin
         lvalid_n = |db;
         latest_n = (|db) ? lowest_idx(db) : '0;
      end
   end

   assign timeout_hit = sample_tick && (tcnt == 8'(EDGE_TIMEOUT - 1));

   always_comb begin
      state_n = state;
      idx_n   = note_idx;
      on_n    = note_on;
      tcnt_n  = tcnt;
      case (state)
         IDLE: begin
            if (lvalid) begin
               idx_n   = latest;
               on_n    = 1'b1;
               state_n = PLAY;
            end
         end
         PLAY: begin
            if (!lvalid || latest != note_idx) begin
               state_n = WAIT;
               tcnt_n  = '0;
            end
         end
         WAIT: begin
            if (lvalid && latest == note_idx) begin
               state_n = PLAY;
            end else if (wave_edge || timeout_hit) begin
               on_n    = lvalid;
               idx_n   = lvalid ? latest : '0;
               state_n = lvalid ? PLAY : IDLE;
            end else if (sample_tick) begin
               tcnt_n = tcnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
      sel_n = on_n ? (12'd1 << idx_n) : 12'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         db_prev  <= '0;
         latest   <= '0;
         lvalid   <= 1'b0;
         state    <= IDLE;
         note_idx <= '0;
         note_on  <= 1'b0;
         key_sel  <= '0;
         tcnt     <= '0;
      end else begin
         db_prev  <= db;
         latest   <= latest_n;
         lvalid   <= lvalid_n;
         state    <= state_n;
         note_idx <= idx_n;
         note_on  <= on_n;
         key_sel  <= sel_n;
         tcnt     <= tcnt_n;
      end
   end

   assign pending   = (state == WAIT);
   assign dbg_state = state;

endmodule

// File: tb/tb_note_key_scheduler.sv
// Directed bench for note_key_scheduler: debounce latency, glitch rejection,
// last-note priority, edge-gated changes, timeout and candidate revert.
module tb_note_key_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] keys;
   logic        sample_tick;
   logic        wave_edge;
   logic [11:0] key_sel;
   logic        note_on;
   logic [3:0]  note_idx;
   logic        pending;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   note_key_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .keys        (keys),
      .sample_tick (sample_tick),
      .wave_edge   (wave_edge),
      .key_sel     (key_sel),
      .note_on     (note_on),
      .note_idx    (note_idx),
      .pending     (pending),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   // One clock with the given strobes; returns 1 time unit after the edge.
   task automatic cyc(input logic t, input logic e);
      sample_tick = t;
      wave_edge   = e;
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
      wave_edge   = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) cyc(1'b1, 1'b0);
   endtask

   task automatic settle(input logic [11:0] k);
      keys = k;
      ticks(240);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      rst = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic on, input logic [3:0] idx,
                          input logic [11:0] sel, input logic pend);
      chk({tag, ".note_on"},  16'(note_on),  16'(on));
      chk({tag, ".note_idx"}, 16'(note_idx), 16'(idx));
      chk({tag, ".key_sel"},  16'(key_sel),  16'(sel));
      chk({tag, ".pending"},  16'(pending),  16'(pend));
   endtask

   initial begin
      rst = 1'b1; keys = 12'hFFF; sample_tick = 1'b0; wave_edge = 1'b0;

      // reset with every key held
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
      chk_out("rst", 1'b0, 4'd0, 12'h000, 1'b0);
      chk("rst.state", 16'(dbg_state), 16'd0);
      rst = 1'b0;
      ticks(239);
      chk("rst.239", 16'(note_on), 16'd0);
      ticks(1);
      chk("rst.240", 16'(note_on), 16'd0);
      cyc(1'b0, 1'b0);
      chk("rst.240p1", 16'(note_on), 16'd0);
      cyc(1'b0, 1'b0);
      chk_out("rst.240p2", 1'b1, 4'd0, 12'h001, 1'b0);

      // glitch rejection on key 3
      keys = 12'h000;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         keys = (i % 2 == 0) ? 12'h008 : 12'h000;
         cyc(1'b1, 1'b0);
      end
      chk("bounce.quiet", 16'(note_on), 16'd0);
      keys = 12'h008;
      ticks(239);
      chk("bounce.239", 16'(note_on), 16'd0);
      ticks(1);
      cyc(1'b0, 1'b0);
      chk("bounce.p1", 16'(note_on), 16'd0);
      cyc(1'b0, 1'b0);
      chk_out("bounce.p2", 1'b1, 4'd3, 12'h008, 1'b0);
      chk("bounce.state", 16'(dbg_state), 16'd1);

      // last-note priority: 0, then 9 over it, then release 9
      keys = 12'h000;
      do_reset();
      settle(12'h001);
      chk_out("lnp.k0", 1'b1, 4'd0, 12'h001, 1'b0);
      settle(12'h201);
      chk_out("lnp.wait9", 1'b1, 4'd0, 12'h001, 1'b1);
      cyc(1'b0, 1'b1);
      chk_out("lnp.k9", 1'b1, 4'd9, 12'h200, 1'b0);
      cyc(1'b0, 1'b1);
      chk_out("lnp.edge_in_play", 1'b1, 4'd9, 12'h200, 1'b0);
      settle(12'h001);
      chk_out("lnp.wait0", 1'b1, 4'd9, 12'h200, 1'b1);
      cyc(1'b0, 1'b1);
      chk_out("lnp.back0", 1'b1, 4'd0, 12'h001, 1'b0);

      // edge-gated change 5 -> 7
      keys = 12'h000;
      do_reset();
      settle(12'h020);
      chk_out("gate.k5", 1'b1, 4'd5, 12'h020, 1'b0);
      settle(12'h0A0);
      ticks(50);
      chk_out("gate.held", 1'b1, 4'd5, 12'h020, 1'b1);
      cyc(1'b0, 1'b1);
      chk_out("gate.k7", 1'b1, 4'd7, 12'h080, 1'b0);

      // timeout: release everything, never send wave_edge
      settle(12'h000);
      chk_out("tmo.enter", 1'b1, 4'd7, 12'h080, 1'b1);
      ticks(254);
      chk_out("tmo.254", 1'b1, 4'd7, 12'h080, 1'b1);
      ticks(1);
      chk_out("tmo.255", 1'b0, 4'd0, 12'h000, 1'b0);
      chk("tmo.state", 16'(dbg_state), 16'd0);

      // candidate reverts during WAIT: 8 pressed and released over 2
      do_reset();
      settle(12'h004);
      chk_out("rev.k2", 1'b1, 4'd2, 12'h004, 1'b0);
      settle(12'h104);
      chk_out("rev.wait", 1'b1, 4'd2, 12'h004, 1'b1);
      keys = 12'h004;
      ticks(120);
      chk_out("rev.mid", 1'b1, 4'd2, 12'h004, 1'b1);
      ticks(120);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      chk_out("rev.back", 1'b1, 4'd2, 12'h004, 1'b0);
      chk("rev.state", 16'(dbg_state), 16'd1);

      // reset while waiting discards the pending change
      settle(12'h104);
      chk("rstwait.pend", 16'(pending), 16'd1);
      do_reset();
      chk_out("rstwait.out", 1'b0, 4'd0, 12'h000, 1'b0);
      ticks(10);
      chk_out("rstwait.after", 1'b0, 4'd0, 12'h000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
